hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W).
- Keeps a shadow pipeline of destination-register info for the instructions in E, M and W, fed from decode-stage control signals.
- Generates the E-stage operand forwarding selects, the load-use stall, and the taken-branch flush.
- Keeps saturating stall and flush event counters for bring-up.

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage F/D/E/M/W core: E-stage forwarding selects, stalls, flushes and event counters.
// Build macro HAZARD_FORWARDING_EN enables forwarding; without it every RAW dependence on E or M stalls D.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regWrite,
    input  logic             id_ResultSrc,
    input  logic             ex_branch_taken,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [4:0] e_rs1, e_rs2, e_rd, m_rd, w_rd;
    logic       e_rw, e_ld, m_rw, w_rw;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic [1:0] fwd_a, fwd_b;
    logic       hazard;
    logic       stall_d, flush_d, flush_e;

`ifdef HAZARD_FORWARDING_EN
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (m_rw && m_rd != 5'd0 && m_rd == e_rs1)      fwd_a = 2'b10;
        else if (w_rw && w_rd != 5'd0 && w_rd == e_rs1) fwd_a = 2'b01;
        if (m_rw && m_rd != 5'd0 && m_rd == e_rs2)      fwd_b = 2'b10;
        else if (w_rw && w_rd != 5'd0 && w_rd == e_rs2) fwd_b = 2'b01;
    end

    // Only a load in E is too late to forward; ALU results reach E from M/W.
    assign hazard = id_valid & e_ld & e_rw & (e_rd != 5'd0) &
                    ((e_rd == id_rs1) | (e_rd == id_rs2));
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;

    // Without forwarding, D waits until the producer has reached W (write-first regfile).
    assign hazard = id_valid &
                    ((e_rw & (e_rd != 5'd0) & ((e_rd == id_rs1) | (e_rd == id_rs2))) |
                     (m_rw & (m_rd != 5'd0) & ((m_rd == id_rs1) | (m_rd == id_rs2))));

    logic unused_slots;
    assign unused_slots = ^{e_rs1, e_rs2, e_ld, w_rd, w_rw};
`endif

    // A taken branch discards the stalled D instruction, so it overrides the stall.
    always_comb begin
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst) begin
            stall_d = hazard & ~ex_branch_taken;
            flush_d = ex_branch_taken;
            flush_e = hazard | ex_branch_taken;
        end
    end

    always_comb begin
        ForwardA  = rst ? 2'b00 : fwd_a;
        ForwardB  = rst ? 2'b00 : fwd_b;
        StallF    = stall_d;
        StallD    = stall_d;
        FlushD    = flush_d;
        FlushE    = flush_e;
        stall_cnt = rst ? '0 : stall_q;
        flush_cnt = rst ? '0 : flush_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_rs1   <= 5'd0;
            e_rs2   <= 5'd0;
            e_rd    <= 5'd0;
            e_rw    <= 1'b0;
            e_ld    <= 1'b0;
            m_rd    <= 5'd0;
            m_rw    <= 1'b0;
            w_rd    <= 5'd0;
            w_rw    <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (flush_e || !id_valid) begin
                e_rs1 <= 5'd0;
                e_rs2 <= 5'd0;
                e_rd  <= 5'd0;
                e_rw  <= 1'b0;
                e_ld  <= 1'b0;
            end else begin
                e_rs1 <= id_rs1;
                e_rs2 <= id_rs2;
                e_rd  <= id_rd;
                e_rw  <= id_regWrite;
                e_ld  <= id_ResultSrc;
            end
            m_rd <= e_rd;
            m_rw <= e_rw;
            w_rd <= m_rd;
            w_rw <= m_rw;
            if (stall_d && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + CNT_W'(1);
            if (flush_d && flush_q != {CNT_W{1'b1}}) flush_q <= flush_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against an instruction-history model.
// Compile with or without HAZARD_FORWARDING_EN to match the RTL build.
module tb_hazard_ctrl;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_req = 1'b1;
    logic id_valid = 1'b0, id_regWrite = 1'b0, id_ResultSrc = 1'b0, ex_branch_taken = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [1:0] ForwardA, ForwardB;
    logic StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_ResultSrc(id_ResultSrc),
        .ex_branch_taken(ex_branch_taken), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Instruction history: index 0 is the instruction now in E, 1 in M, 2 in W.
    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld;
    } rec_t;
    rec_t hist_q[$];
    int exp_stall_cnt = 0;
    int exp_flush_cnt = 0;

    function automatic logic writes(input rec_t r, input logic [4:0] rn);
        return r.rw && r.rd != 5'd0 && r.rd == rn;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
`ifdef HAZARD_FORWARDING_EN
        if (writes(hist_q[1], rs)) return 2'b10;
        if (writes(hist_q[2], rs)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic logic model_hazard();
`ifdef HAZARD_FORWARDING_EN
        return id_valid && hist_q[0].ld && (writes(hist_q[0], id_rs1) || writes(hist_q[0], id_rs2));
`else
        return id_valid && (writes(hist_q[0], id_rs1) || writes(hist_q[0], id_rs2) ||
                            writes(hist_q[1], id_rs1) || writes(hist_q[1], id_rs2));
`endif
    endfunction

    // {ForwardA, ForwardB, StallF, StallD, FlushD, FlushE}
    function automatic logic [7:0] model_ctrl();
        logic st;
        if (rst) return 8'h00;
        st = model_hazard() && !ex_branch_taken;
        return {model_fwd(hist_q[0].rs1), model_fwd(hist_q[0].rs2), st, st,
                ex_branch_taken, model_hazard() || ex_branch_taken};
    endfunction

    task automatic clear_model();
        hist_q.delete();
        repeat (3) hist_q.push_back('0);
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic rw, input logic ld, input logic br);
        @(negedge clk);
        rst = rst_req;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_regWrite = rw; id_ResultSrc = ld; ex_branch_taken = br;
        #1;
    endtask

    // Advance the model by one clock using the inputs currently applied, then take the edge.
    task automatic tick();
        logic [7:0] c;
        rec_t nxt;
        c = model_ctrl();
        if (rst) begin
            clear_model();
        end else begin
            nxt = (c[0] || !id_valid) ? rec_t'(0) : rec_t'{id_rs1, id_rs2, id_rd, id_regWrite, id_ResultSrc};
            hist_q.push_front(nxt);
            void'(hist_q.pop_back());
            if (c[2] && exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
            if (c[1] && exp_flush_cnt < CNT_MAX) exp_flush_cnt++;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd7, 5'd7, 5'd7, 1, 1, 1'($urandom_range(0, 1)));
            checks++;
            if ({ForwardA, ForwardB, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt} !== '0) begin
                failures++;
                $display("FAIL reset_outputs got=%h %h %b%b%b%b %0d %0d exp=all zero",
                         ForwardA, ForwardB, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt);
            end
            tick();
        end
        rst_req = 1'b0;
    endtask

`ifdef HAZARD_FORWARDING_EN
    task automatic test_alu_back_to_back();
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd6, 5'd8, 1, 0, 0);
        checks++;
        if (StallD !== 1'b0 || FlushE !== 1'b0) begin
            failures++; $display("FAIL b2b_no_stall got=%b%b exp=00", StallD, FlushE);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ForwardA !== 2'b10) begin
            failures++; $display("FAIL b2b_fwd_m got=%b exp=10", ForwardA);
        end
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd1, 5'd2, 5'd6, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd6, 5'd8, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ForwardA !== 2'b01 || ForwardB !== 2'b10) begin
            failures++; $display("FAIL b2b_fwd_w got=%b/%b exp=01/10", ForwardA, ForwardB);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd7, 1, 1, 0); tick();
        drive(1, 5'd4, 5'd7, 5'd8, 1, 0, 0);
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
            failures++; $display("FAIL load_use_stall got=%b exp=1101", {StallF, StallD, FlushD, FlushE});
        end
        tick();
        drive(1, 5'd4, 5'd7, 5'd8, 1, 0, 0);
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            failures++; $display("FAIL load_use_one_cycle got=%b exp=000", {StallF, StallD, FlushE});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ForwardB !== 2'b01 || stall_cnt !== CNT_W'(1)) begin
            failures++; $display("FAIL load_use_fwd got=%b cnt=%0d exp=01 cnt=1", ForwardB, stall_cnt);
        end
    endtask

    task automatic test_double_match();
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 0); tick();
        drive(1, 5'd3, 5'd4, 5'd9, 1, 0, 0); tick();
        drive(1, 5'd9, 5'd4, 5'd10, 1, 0, 0);
        checks++;
        if (StallD !== 1'b0) begin
            failures++; $display("FAIL double_no_stall got=%b exp=0", StallD);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ForwardA !== 2'b10) begin
            failures++; $display("FAIL double_m_priority got=%b exp=10", ForwardA);
        end
    endtask
`else
    task automatic test_raw_stall();
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd5, 5'd6, 5'd8, 1, 0, 0);
            checks++;
            if ({StallF, StallD, FlushE} !== ((i < 2) ? 3'b111 : 3'b000) || ForwardA !== 2'b00) begin
                failures++;
                $display("FAIL raw_stall_cycle%0d got=%b fwd=%b exp=%b fwd=00",
                         i, {StallF, StallD, FlushE}, ForwardA, (i < 2) ? 3'b111 : 3'b000);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ForwardA !== 2'b00 || stall_cnt !== CNT_W'(2)) begin
            failures++; $display("FAIL raw_after got=%b cnt=%0d exp=00 cnt=2", ForwardA, stall_cnt);
        end
    endtask
`endif

    task automatic test_branch_during_stall();
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd3, 1, 1, 0); tick();
        drive(1, 5'd3, 5'd4, 5'd8, 1, 0, 1);
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            failures++; $display("FAIL branch_wins got=%b exp=0011", {StallF, StallD, FlushD, FlushE});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (flush_cnt !== CNT_W'(1) || stall_cnt !== CNT_W'(0)) begin
            failures++; $display("FAIL branch_counts got=%0d/%0d exp=1/0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_x0_guard();
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd0, 1, 1, 0); tick();
        drive(1, 5'd0, 5'd0, 5'd4, 0, 0, 0);
        checks++;
        if (StallD !== 1'b0 || FlushE !== 1'b0) begin
            failures++; $display("FAIL x0_no_stall got=%b%b exp=00", StallD, FlushE);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ForwardA !== 2'b00 || ForwardB !== 2'b00 || stall_cnt !== CNT_W'(0)) begin
            failures++; $display("FAIL x0_no_fwd got=%b/%b cnt=%0d exp=00/00 cnt=0", ForwardA, ForwardB, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd7, 1, 1, 0); tick();
        drive(1, 5'd4, 5'd7, 5'd8, 1, 0, 0);
        checks++;
        if (StallD !== 1'b1) begin
            failures++; $display("FAIL midrst_pre got=%b exp=1", StallD);
        end
        rst_req = 1'b1;
        drive(1, 5'd4, 5'd7, 5'd8, 1, 0, 0);
        checks++;
        if ({ForwardA, ForwardB, StallF, StallD, FlushD, FlushE} !== 8'h00) begin
            failures++; $display("FAIL midrst_during got=%b exp=0", {ForwardA, ForwardB, StallF, StallD, FlushD, FlushE});
        end
        tick();
        rst_req = 1'b0;
        drive(1, 5'd7, 5'd7, 5'd9, 1, 0, 0);
        checks++;
        if ({ForwardA, ForwardB, StallF, StallD, FlushD, FlushE} !== 8'h00 ||
            stall_cnt !== '0 || flush_cnt !== '0) begin
            failures++; $display("FAIL midrst_after got=%b cnt=%0d/%0d exp=0 cnt=0/0",
                                 {ForwardA, ForwardB, StallF, StallD, FlushD, FlushE}, stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            drive(1, 5'd1, 5'd2, 5'd7, 1, 1, 0); tick();
            drive(1, 5'd7, 5'd3, 5'd8, 1, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_cnt !== CNT_W'(CNT_MAX)) begin
            failures++; $display("FAIL stall_saturate got=%0d exp=%0d", stall_cnt, CNT_MAX);
        end
        tick();
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (flush_cnt !== CNT_W'(CNT_MAX) || stall_cnt !== CNT_W'(CNT_MAX)) begin
            failures++; $display("FAIL flush_saturate got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, CNT_MAX, CNT_MAX);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_c;
        logic [CNT_W-1:0] exp_s, exp_f;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_req = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 99) < 85), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 99) < 10));
            exp_c = model_ctrl();
            exp_s = rst ? '0 : CNT_W'(exp_stall_cnt);
            exp_f = rst ? '0 : CNT_W'(exp_flush_cnt);
            checks++;
            if ({ForwardA, ForwardB, StallF, StallD, FlushD, FlushE} !== exp_c) begin
                failures++; $display("FAIL rand_ctrl cycle=%0d got=%b exp=%b", i,
                                     {ForwardA, ForwardB, StallF, StallD, FlushD, FlushE}, exp_c);
            end
            checks++;
            if (stall_cnt !== exp_s || flush_cnt !== exp_f) begin
                failures++; $display("FAIL rand_cnt cycle=%0d got=%0d/%0d exp=%0d/%0d", i,
                                     stall_cnt, flush_cnt, exp_s, exp_f);
            end
            tick();
        end
        rst_req = 1'b0;
    endtask

    initial begin
        clear_model();
        test_reset();
`ifdef HAZARD_FORWARDING_EN
        test_alu_back_to_back();
        test_load_use();
        test_double_match();
`else
        test_raw_stall();
`endif
        test_branch_during_stall();
        test_x0_guard();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
